// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave backed by a 2^ADDR_WIDTH x 32-bit word RAM, independent read/write FSMs.
// Optional macro AXI_SLV_RANGE_CHECK_EN: out-of-range accesses answer SLVERR instead of aliasing.
module axi_lite_ram_slave #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] axi_araddr,
   input  logic        axi_arvalid,
   output logic        axi_arready,
   input  logic [2:0]  axi_arprot,
   output logic [31:0] axi_rdata,
   output logic [1:0]  axi_rresp,
   output logic        axi_rvalid,
   input  logic        axi_rready,
   input  logic [31:0] axi_awaddr,
   input  logic        axi_awvalid,
   output logic        axi_awready,
   input  logic [2:0]  axi_awprot,
   input  logic [31:0] axi_wdata,
   input  logic [3:0]  axi_wstrb,
   input  logic        axi_wvalid,
   output logic        axi_wready,
   output logic [1:0]  axi_bresp,
   output logic        axi_bvalid,
   input  logic        axi_bready
);

   localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {R_IDLE = 2'd0, R_MEM = 2'd1, R_RESP = 2'd2} rstate_e;
   typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} wstate_e;

   rstate_e     rstate_q, rstate_d;
   wstate_e     wstate_q, wstate_d;
   logic [31:0] mem_q [DEPTH];
   logic [31:0] araddr_q, awaddr_q, wdata_q, rdata_q;
   logic [3:0]  wstrb_q;
   logic [1:0]  rresp_q, bresp_q;
   logic        aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
   logic        arready_s, awready_s, wready_s, ar_hs_s, aw_hs_s, w_hs_s;
   logic        rd_ok_s, wr_ok_s;
   logic        unused_s;

   function automatic logic [ADDR_WIDTH-1:0] word_idx(input logic [31:0] a);
      return ADDR_WIDTH'((a - BASE_ADDR) >> 2);
   endfunction

   function automatic logic in_range(input logic [31:0] a);
      logic [32:0] diff;
      diff = {1'b0, a} - {1'b0, BASE_ADDR};
      return !diff[32] && ((diff[31:0] >> (ADDR_WIDTH + 2)) == 32'd0);
   endfunction

`ifdef AXI_SLV_RANGE_CHECK_EN
   assign rd_ok_s = in_range(araddr_q);
   assign wr_ok_s = in_range(awaddr_q);
`else
   assign rd_ok_s = 1'b1;
   assign wr_ok_s = 1'b1;
`endif

   assign unused_s = ^{axi_arprot, axi_awprot};

   // Read FSM next state and AR ready decode
   always_comb begin
      rstate_d  = rstate_q;
      arready_s = 1'b0;
      ar_hs_s   = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            arready_s = 1'b1;
            if (axi_arvalid) begin
               ar_hs_s  = 1'b1;
               rstate_d = R_MEM;
            end else begin
               rstate_d = R_IDLE;
            end
         end
         R_MEM:   rstate_d = R_RESP;
         R_RESP: begin
            if (axi_rready) rstate_d = R_IDLE;
            else            rstate_d = R_RESP;
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // Read state, address latch and registered read data/response
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rstate_q <= R_IDLE;
         araddr_q <= 32'd0;
         rdata_q  <= 32'd0;
         rresp_q  <= RESP_OKAY;
      end else begin
         rstate_q <= rstate_d;
         if (ar_hs_s) araddr_q <= axi_araddr;
         if (rstate_q == R_MEM) begin
            rdata_q <= rd_ok_s ? mem_q[word_idx(araddr_q)] : 32'd0;
            rresp_q <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   // Write FSM: AW and W latched independently, commit once both are held
   always_comb begin
      wstate_d  = wstate_q;
      aw_lat_d  = aw_lat_q;
      w_lat_d   = w_lat_q;
      awready_s = 1'b0;
      wready_s  = 1'b0;
      aw_hs_s   = 1'b0;
      w_hs_s    = 1'b0;
      case (wstate_q)
         W_IDLE: begin
            awready_s = !aw_lat_q;
            wready_s  = !w_lat_q;
            aw_hs_s   = axi_awvalid && awready_s;
            w_hs_s    = axi_wvalid && wready_s;
            if (aw_hs_s) aw_lat_d = 1'b1;
            else         aw_lat_d = aw_lat_q;
            if (w_hs_s) w_lat_d = 1'b1;
            else        w_lat_d = w_lat_q;
            if (aw_lat_d && w_lat_d) wstate_d = W_COMMIT;
            else                     wstate_d = W_IDLE;
         end
         W_COMMIT: wstate_d = W_RESP;
         W_RESP: begin
            if (axi_bready) begin
               wstate_d = W_IDLE;
               aw_lat_d = 1'b0;
               w_lat_d  = 1'b0;
            end else begin
               wstate_d = W_RESP;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Write state, channel latches and registered write response
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wstate_q <= W_IDLE;
         aw_lat_q <= 1'b0;
         w_lat_q  <= 1'b0;
         awaddr_q <= 32'd0;
         wdata_q  <= 32'd0;
         wstrb_q  <= 4'd0;
         bresp_q  <= RESP_OKAY;
      end else begin
         wstate_q <= wstate_d;
         aw_lat_q <= aw_lat_d;
         w_lat_q  <= w_lat_d;
         if (aw_hs_s) awaddr_q <= axi_awaddr;
         if (w_hs_s) begin
            wdata_q <= axi_wdata;
            wstrb_q <= axi_wstrb;
         end
         if (wstate_q == W_COMMIT) bresp_q <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // RAM byte-lane write; contents survive reset, reads see pre-write data
   always_ff @(posedge clk) begin
      if (rstn && (wstate_q == W_COMMIT) && wr_ok_s) begin
         for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) mem_q[word_idx(awaddr_q)][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   assign axi_arready = arready_s;
   assign axi_awready = awready_s;
   assign axi_wready  = wready_s;
   assign axi_rvalid  = (rstate_q == R_RESP);
   assign axi_bvalid  = (wstate_q == W_RESP);
   assign axi_rdata   = rdata_q;
   assign axi_rresp   = rresp_q;
   assign axi_bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Directed self-checking bench for axi_lite_ram_slave (default parameters).
module tb_axi_lite_ram_slave;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] axi_araddr, axi_rdata, axi_awaddr, axi_wdata;
   logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
   logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_bvalid, axi_bready;
   logic [2:0]  axi_arprot, axi_awprot;
   logic [1:0]  axi_rresp, axi_bresp;
   logic [3:0]  axi_wstrb;

   int n_checks = 0;
   int n_errors = 0;

   axi_lite_ram_slave dut (
      .clk(clk), .rstn(rstn),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_arprot(axi_arprot), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_awprot(axi_awprot), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue AR and wait for rvalid without accepting it; lat counts cycles after handshake
   task automatic start_read(input logic [31:0] a, output int lat);
      int guard = 0;
      @(negedge clk);
      axi_araddr  = a;
      axi_arvalid = 1'b1;
      while (!axi_arready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      @(negedge clk);
      axi_arvalid = 1'b0;
      lat = 1;
      while (!axi_rvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("rvalid_seen", {31'd0, axi_rvalid}, 32'd1);
   endtask

   task automatic ack_r(output logic [31:0] d, output logic [1:0] r);
      d = axi_rdata;
      r = axi_rresp;
      axi_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi_rready = 1'b0;
   endtask

   task automatic start_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              output int lat);
      logic aw_done = 1'b0, w_done = 1'b0, aw_hs, w_hs;
      int   guard = 0;
      @(negedge clk);
      axi_awaddr = a; axi_awvalid = 1'b1;
      axi_wdata = d;  axi_wstrb = s; axi_wvalid = 1'b1;
      while (!(aw_done && w_done) && guard < 20) begin
         aw_hs = axi_awvalid && axi_awready;
         w_hs  = axi_wvalid && axi_wready;
         @(posedge clk);
         @(negedge clk);
         if (aw_hs) begin aw_done = 1'b1; axi_awvalid = 1'b0; end
         if (w_hs)  begin w_done = 1'b1;  axi_wvalid = 1'b0;  end
         guard++;
      end
      axi_awvalid = 1'b0;
      axi_wvalid  = 1'b0;
      lat = 1;
      while (!axi_bvalid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check_eq("bvalid_seen", {31'd0, axi_bvalid}, 32'd1);
   endtask

   task automatic ack_b(output logic [1:0] r);
      r = axi_bresp;
      axi_bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi_bready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
      int lat;
      start_write(a, d, s, lat);
      ack_b(r);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      int lat;
      start_read(a, lat);
      ack_r(d, r);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d, d0;
      logic [1:0]  r;
      int          lat;

      rstn = 1'b0;
      axi_araddr = 32'd0; axi_arvalid = 1'b0; axi_arprot = 3'd0; axi_rready = 1'b0;
      axi_awaddr = 32'd0; axi_awvalid = 1'b0; axi_awprot = 3'd0;
      axi_wdata = 32'd0;  axi_wstrb = 4'd0;   axi_wvalid = 1'b0; axi_bready = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check_eq("rst_rvalid",  {31'd0, axi_rvalid},  32'd0);
      check_eq("rst_bvalid",  {31'd0, axi_bvalid},  32'd0);
      check_eq("rst_rdata",   axi_rdata,            32'd0);
      check_eq("rst_resp",    {28'd0, axi_rresp, axi_bresp}, 32'd0);
      check_eq("rst_readies", {29'd0, axi_arready, axi_awready, axi_wready}, 32'd7);

      // Basic write then read with latency
      start_write(32'h10, 32'hDEADBEEF, 4'hF, lat);
      check_eq("wr_lat", lat, 32'd2);
      ack_b(r);
      check_eq("wr_bresp", {30'd0, r}, 32'd0);
      start_read(32'h10, lat);
      check_eq("rd_lat", lat, 32'd2);
      ack_r(d, r);
      check_eq("rd_data", d, 32'hDEADBEEF);
      check_eq("rd_rresp", {30'd0, r}, 32'd0);

      // Zero strobe leaves word untouched
      do_write(32'h10, 32'hFFFF_FFFF, 4'h0, r);
      check_eq("strb0_bresp", {30'd0, r}, 32'd0);
      do_read(32'h10, d, r);
      check_eq("strb0_data", d, 32'hDEADBEEF);

      // W three cycles ahead of AW, partial strobes
      do_write(32'h20, 32'h0, 4'hF, r);
      @(negedge clk);
      axi_wdata = 32'h11223344; axi_wstrb = 4'b0101; axi_wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi_wvalid = 1'b0;
      check_eq("w_first_wready", {30'd0, axi_wready, axi_awready}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      axi_awaddr = 32'h20; axi_awvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi_awvalid = 1'b0;
      check_eq("w_first_b_n1", {31'd0, axi_bvalid}, 32'd0);
      @(negedge clk);
      check_eq("w_first_b_n2", {31'd0, axi_bvalid}, 32'd1);
      ack_b(r);
      check_eq("w_first_bresp", {30'd0, r}, 32'd0);
      do_read(32'h20, d, r);
      check_eq("w_first_data", d, 32'h00220044);

      // rready held low five cycles with a second AR pending
      start_read(32'h10, lat);
      d0 = axi_rdata;
      axi_araddr = 32'h20; axi_arvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check_eq("hold_rvalid", {31'd0, axi_rvalid}, 32'd1);
         check_eq("hold_rdata", axi_rdata, d0);
         check_eq("hold_arready", {31'd0, axi_arready}, 32'd0);
         @(negedge clk);
      end
      check_eq("hold_value", d0, 32'hDEADBEEF);
      axi_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi_rready = 1'b0;
      check_eq("post_r_rvalid", {31'd0, axi_rvalid}, 32'd0);
      check_eq("post_r_arready", {31'd0, axi_arready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      axi_arvalid = 1'b0;
      check_eq("second_rd_n1", {31'd0, axi_rvalid}, 32'd0);
      @(negedge clk);
      check_eq("second_rd_n2", {31'd0, axi_rvalid}, 32'd1);
      ack_r(d, r);
      check_eq("second_rd_data", d, 32'h00220044);

      // Read-before-write collision on word 0x40
      do_write(32'h40, 32'hAAAA_AAAA, 4'hF, r);
      @(negedge clk);
      axi_araddr = 32'h40; axi_arvalid = 1'b1;
      axi_awaddr = 32'h40; axi_awvalid = 1'b1;
      axi_wdata = 32'h5555_5555; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi_arvalid = 1'b0; axi_awvalid = 1'b0; axi_wvalid = 1'b0;
      @(negedge clk);
      check_eq("coll_valids", {30'd0, axi_rvalid, axi_bvalid}, 32'd3);
      ack_r(d, r);
      check_eq("coll_old", d, 32'hAAAA_AAAA);
      ack_b(r);
      check_eq("coll_bresp", {30'd0, r}, 32'd0);
      do_read(32'h40, d, r);
      check_eq("coll_new", d, 32'h5555_5555);

      // Word index 4096: SLVERR with range check, alias to word 0 without
      do_write(32'h0, 32'h0F0F_0F0F, 4'hF, r);
      do_write(32'h4000, 32'h1234_5678, 4'hF, r);
`ifdef AXI_SLV_RANGE_CHECK_EN
      check_eq("oor_bresp", {30'd0, r}, 32'd2);
      do_read(32'h0, d, r);
      check_eq("oor_word0", d, 32'h0F0F_0F0F);
      do_read(32'h4000, d, r);
      check_eq("oor_rdata", d, 32'd0);
      check_eq("oor_rresp", {30'd0, r}, 32'd2);
`else
      check_eq("alias_bresp", {30'd0, r}, 32'd0);
      do_read(32'h0, d, r);
      check_eq("alias_word0", d, 32'h1234_5678);
      check_eq("alias_rresp", {30'd0, r}, 32'd0);
`endif

      // Reset while bvalid pending, then with only W latched
      start_write(32'h80, 32'hCAFE_F00D, 4'hF, lat);
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      check_eq("rst_mid_bvalid", {31'd0, axi_bvalid}, 32'd0);
      check_eq("rst_mid_readies", {29'd0, axi_arready, axi_awready, axi_wready}, 32'd7);
      axi_wdata = 32'h0BAD_BEEF; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi_wvalid = 1'b0;
      rstn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      check_eq("rst_w_wready", {31'd0, axi_wready}, 32'd1);
      do_write(32'h84, 32'h1357_9BDF, 4'hF, r);
      check_eq("fresh_bresp", {30'd0, r}, 32'd0);
      do_read(32'h84, d, r);
      check_eq("fresh_data", d, 32'h1357_9BDF);
      do_read(32'h80, d, r);
      check_eq("pre_rst_commit", d, 32'hCAFE_F00D);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
